// File: rtl/seq_det_param_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// pattern-length limits, fill-counter sizing and a saturating increment.
package seq_det_pkg;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    // Detection mode selected by the overlap input.
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Width of a counter that must hold the values 0..pat_len.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Serial stream, control and status signals of the sequence detector.
// i is qualified by i_vld: a bit is consumed only on a rising clk edge with
// i_vld=1; there is no back-pressure, the detector accepts every valid bit.
// pat_load outranks i_vld on the same edge.
interface seq_det_param_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
);
    logic               i;
    logic               i_vld;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               cnt_clr;
    logic               q;
    logic [CNT_W-1:0]   match_cnt;
    logic [PAT_LEN-1:0] pat;

    modport master (
        output i, i_vld, overlap, pat_load, pat_in, cnt_clr,
        input  q, match_cnt, pat
    );

    modport slave (
        input  i, i_vld, overlap, pat_load, pat_in, cnt_clr,
        output q, match_cnt, pat
    );
endinterface

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [31:0] MAX_V = 32'((64'(1) << W) - 64'(1));

    // Clear wins over increment; increment sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= W'(sat_inc(32'(cnt), MAX_V));
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised Moore serial sequence detector with runtime pattern reload,
// selectable overlapping/non-overlapping detection and a match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PAT_RST = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input logic            clk,
    input logic            rst,
    seq_det_param_if.slave bus
);

    localparam int             FW        = fill_width(PAT_LEN);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] pat_r;
    logic [FW-1:0]      fill;
    logic               q_r;
    logic [PAT_LEN-1:0] nh;
    logic [FW-1:0]      nf;
    logic               hit;
    ovl_mode_e          mode;
    logic [CNT_W-1:0]   cnt;

    // Candidate next history/fill and the match decision for this edge.
    always_comb begin
        nh   = {hist[PAT_LEN-2:0], bus.i};
        nf   = (fill == FILL_FULL) ? fill : fill + FW'(1);
        mode = ovl_mode_e'(bus.overlap);
        hit  = bus.i_vld && !bus.pat_load && (nf == FILL_FULL) && (nh == pat_r);
    end

    // Detector state: pattern load flushes, valid bits shift in, idle edges hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            pat_r <= PAT_RST;
            q_r   <= 1'b0;
        end else if (bus.pat_load) begin
            pat_r <= bus.pat_in;
            hist  <= '0;
            fill  <= '0;
            q_r   <= 1'b0;
        end else if (bus.i_vld) begin
            q_r <= hit;
            if (hit && (mode == OVL_OFF)) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= nh;
                fill <= nf;
            end
        end else begin
            q_r <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (bus.cnt_clr),
        .cnt (cnt)
    );

    assign bus.q         = q_r;
    assign bus.match_cnt = cnt;
    assign bus.pat       = pat_r;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: a 3-bit "101" instance checked against a
// queue-based reference model, and a 2-bit "11" instance with a 2-bit
// counter for saturation and clear-versus-hit.
module tb_seq_det_param;
    import seq_det_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_det_param_if #(.PAT_LEN(3), .CNT_W(8)) a ();
    seq_det_param_if #(.PAT_LEN(2), .CNT_W(2)) b ();

    seq_det_param #(.PAT_LEN(3), .PAT_RST(3'b101), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    seq_det_param #(.PAT_LEN(2), .PAT_RST(2'b11), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for instance a: bits received since the last flush.
    logic       bits_q[$];
    logic [2:0] m_pat;
    int         m_cnt;
    logic [0:0] exp_q[$];

    function automatic void model_reset();
        bits_q.delete();
        exp_q.delete();
        m_pat = 3'b101;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input logic bi, input logic v, input logic o,
                                       input logic l, input logic [2:0] p, input logic c);
        logic hit;
        hit = 1'b0;
        if (l) begin
            m_pat = p;
            bits_q.delete();
        end else if (v) begin
            bits_q.push_back(bi);
            if (bits_q.size() > 3) void'(bits_q.pop_front());
            if (bits_q.size() == 3)
                hit = (bits_q[0] == m_pat[2]) && (bits_q[1] == m_pat[1]) && (bits_q[2] == m_pat[0]);
            if (hit && !o) bits_q.delete();
        end
        if (c) m_cnt = 0;
        else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
        exp_q.push_back(hit);
    endfunction

    // Driver tasks
    task automatic drive_a(input logic bi, input logic v, input logic o,
                           input logic l, input logic [2:0] p, input logic c);
        @(negedge clk);
        a.i = bi; a.i_vld = v; a.overlap = o; a.pat_load = l; a.pat_in = p; a.cnt_clr = c;
        @(posedge clk);
        model_step(bi, v, o, l, p, c);
        #1;
    endtask

    task automatic drive_b(input logic bi, input logic v, input logic c);
        @(negedge clk);
        b.i = bi; b.i_vld = v; b.overlap = 1'b1; b.pat_load = 1'b0; b.pat_in = 2'b11; b.cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a.i = 0; a.i_vld = 0; a.overlap = 0; a.pat_load = 0; a.pat_in = 3'b000; a.cnt_clr = 0;
        b.i = 0; b.i_vld = 0; b.overlap = 0; b.pat_load = 0; b.pat_in = 2'b00; b.cnt_clr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (a.q !== 1'b0) begin bad++; $display("FAIL reset_q got=%0b exp=0", a.q); end
        total++; if (a.match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a.match_cnt); end
        total++; if (a.pat !== 3'b101) begin bad++; $display("FAIL reset_pat got=%b exp=101", a.pat); end
        total++; if (b.pat !== 2'b11) begin bad++; $display("FAIL reset_pat_b got=%b exp=11", b.pat); end
    endtask

    task automatic test_non_overlap();
        logic [4:0] s;
        logic [0:0] e;
        s = 5'b10101;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive_a(s[4-k], 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
            e = exp_q.pop_front();
            total++; if (a.q !== e[0]) begin bad++; $display("FAIL nonovl_q step=%0d got=%0b exp=%0b", k, a.q, e[0]); end
            total++; if (a.q !== (k == 2)) begin bad++; $display("FAIL nonovl_q_abs step=%0d got=%0b exp=%0b", k, a.q, (k == 2)); end
        end
        total++; if (a.match_cnt !== 8'd1) begin bad++; $display("FAIL nonovl_cnt got=%0d exp=1", a.match_cnt); end
    endtask

    task automatic test_overlap();
        logic [8:0] s;
        logic [0:0] e;
        s = 9'b10101_1101;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive_a(s[8-k], 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
            e = exp_q.pop_front();
            total++; if (a.q !== e[0]) begin bad++; $display("FAIL ovl_q step=%0d got=%0b exp=%0b", k, a.q, e[0]); end
            total++; if (a.match_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL ovl_cnt step=%0d got=%0d exp=%0d", k, a.match_cnt, m_cnt); end
            if (k == 4) begin
                total++; if (a.match_cnt !== 8'd2) begin bad++; $display("FAIL ovl_cnt5 got=%0d exp=2", a.match_cnt); end
            end
        end
        total++; if (a.match_cnt !== 8'd3) begin bad++; $display("FAIL ovl_cnt_final got=%0d exp=3", a.match_cnt); end
    endtask

    task automatic test_vld_gaps();
        logic [6:0] bits;
        logic [6:0] vld;
        logic [0:0] e;
        bits = 7'b1000001;
        vld  = 7'b1000101;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive_a(vld[6-k] ? bits[6-k] : 1'($urandom_range(0, 1)), vld[6-k], 1'b0, 1'b0, 3'b000, 1'b0);
            e = exp_q.pop_front();
            total++; if (a.q !== e[0]) begin bad++; $display("FAIL gap_q step=%0d got=%0b exp=%0b", k, a.q, e[0]); end
            total++; if (a.q !== (k == 6)) begin bad++; $display("FAIL gap_q_abs step=%0d got=%0b exp=%0b", k, a.q, (k == 6)); end
        end
    endtask

    task automatic test_pat_load();
        logic [0:0] e;
        apply_reset();
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
        total++; if (a.pat !== 3'b110) begin bad++; $display("FAIL load_pat got=%b exp=110", a.pat); end
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        total++; if (a.q !== 1'b0) begin bad++; $display("FAIL load_early_q got=%0b exp=0", a.q); end
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        total++; if (a.q !== 1'b1) begin bad++; $display("FAIL load_hit_q got=%0b exp=1", a.q); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            if (k == 5) begin
                total++; if (e[0] !== 1'b1) begin bad++; $display("FAIL load_model_q got=%0b exp=1", e[0]); end
            end
        end
        total++; if (a.match_cnt !== 8'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", a.match_cnt); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 1; k <= 7; k++) begin
            drive_b(1'b1, 1'b1, 1'b0);
            total++; if (b.q !== (k >= 2)) begin bad++; $display("FAIL sat_q bit=%0d got=%0b exp=%0b", k, b.q, (k >= 2)); end
            total++; if (b.match_cnt !== 2'((k - 1 > 3) ? 3 : k - 1)) begin
                bad++; $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", k, b.match_cnt, (k - 1 > 3) ? 3 : k - 1);
            end
        end
        drive_b(1'b1, 1'b1, 1'b1);
        total++; if (b.q !== 1'b1) begin bad++; $display("FAIL clr_hit_q got=%0b exp=1", b.q); end
        total++; if (b.match_cnt !== 2'd0) begin bad++; $display("FAIL clr_hit_cnt got=%0d exp=0", b.match_cnt); end
        drive_b(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [0:0] e;
        apply_reset();
        drive_a(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0);
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        total++; if (a.q !== 1'b1) begin bad++; $display("FAIL arst_pre_q got=%0b exp=1", a.q); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (a.q !== 1'b0) begin bad++; $display("FAIL arst_q got=%0b exp=0", a.q); end
        total++; if (a.match_cnt !== 8'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", a.match_cnt); end
        total++; if (a.pat !== 3'b101) begin bad++; $display("FAIL arst_pat got=%b exp=101", a.pat); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        e = exp_q.pop_front();
        total++; if (a.q !== e[0] || a.q !== 1'b0) begin bad++; $display("FAIL arst_lost_q got=%0b exp=0", a.q); end
    endtask

    task automatic test_random();
        logic [0:0] e;
        logic       l;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            l = ($urandom_range(0, 19) == 0);
            drive_a(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    l, 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
            e = exp_q.pop_front();
            total++; if (a.q !== e[0]) begin bad++; $display("FAIL rnd_q step=%0d got=%0b exp=%0b", k, a.q, e[0]); end
            total++; if (a.match_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_cnt step=%0d got=%0d exp=%0d", k, a.match_cnt, m_cnt); end
            total++; if (a.pat !== m_pat) begin bad++; $display("FAIL rnd_pat step=%0d got=%b exp=%b", k, a.pat, m_pat); end
        end
    endtask

    // Test sequence and final report
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_non_overlap();
        test_overlap();
        test_vld_gaps();
        test_pat_load();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised Moore-style serial sequence detector, successor to the fixed 3-bit "101" detectors.
- Supports:
  - pattern length from 2 to 16 bits;
  - a pattern that can be reloaded at runtime;
  - a runtime choice of overlapping or non-overlapping detection;
  - an input-valid qualifier;
  - a saturating match counter.
- Sits on a 1-bit serial stream, e.g. behind a UART/line receiver, and flags frame markers to downstream control logic.

Parameters:
- PAT_LEN, 3: pattern length in bits. Legal range 2..16.
- PAT_RST, 3'b101: pattern loaded at reset, PAT_LEN bits wide. Bit PAT_LEN-1 is received first.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i  in  1  serial data bit.
- i_vld  in  1  i is sampled only on edges where i_vld=1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping. Sampled every valid edge.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_LEN  new pattern value.
- cnt_clr  in  1  synchronous clear of match_cnt.
- q  out  1  registered detect flag (Moore).
- match_cnt  out  CNT_W  number of matches, saturating.
- pat  out  PAT_LEN  currently active pattern.

Behaviour:
- Reset (asynchronous, active-high):
  - q=0, match_cnt=0, pat=PAT_RST;
  - history register hist=0, fill counter fill=0.
- Internal state:
  - hist is a PAT_LEN-bit shift register; new bits enter at the LSB.
  - fill counts received bits since the last clear and saturates at PAT_LEN. Width is clog2(PAT_LEN+1).
- On a valid edge (i_vld=1, pat_load=0):
  - nh = {hist[PAT_LEN-2:0], i};
  - nf = min(fill+1, PAT_LEN);
  - hit = (nf==PAT_LEN) && (nh==pat).
- Registering the result:
  - q <= hit.
  - On a hit with overlap=1: hist<=nh, fill<=nf. The last bits can start the next match.
  - On a hit with overlap=0: hist<=0, fill<=0. The next match needs PAT_LEN fresh bits.
  - No hit: hist<=nh, fill<=nf.
- Latency and Moore timing:
  - q rises on the edge that samples the final pattern bit, so it is high during the following cycle.
  - q stays high for exactly one cycle per match.
- Invalid edge (i_vld=0): hist, fill and match_cnt hold, and q<=0.
- Pattern load (pat_load=1):
  - pat<=pat_in, hist<=0, fill<=0, q<=0.
  - The stream bit on that edge is discarded, even if i_vld=1.
  - pat_load has priority over i_vld.
- Match counter:
  - Increments on each edge where hit=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces match_cnt<=0. If cnt_clr and hit occur on the same edge, the result is 0: clear wins and the hit is not counted. q still pulses.
- Overlap toggling: a change on overlap takes effect for the hit decision on that same edge. No state flush occurs.
- Reset mid-stream: all state returns immediately to reset values and any partial match is lost.
- Equivalence: for PAT_LEN=3, PAT_RST=101, overlap=0, q must match the legacy 101 non-overlapping Moore detector timing (1 cycle after the last bit).

Decomposition:
- Shared package seq_det_pkg. It holds:
  - the PAT_LEN limits (min 2, max 16);
  - a function for fill-counter width, clog2(PAT_LEN+1);
  - a saturating-increment function reused by other counters in the design.
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr with clr priority; output cnt).
- The detector core (hist/fill/hit) stays in the top module.

Test Plan:
- Default pattern 101, overlap=0, i_vld=1, stream 1,0,1,0,1 → q high after bit 3 only. After bit 5 there is no match because fill was cleared. match_cnt=1.
- Same stream with overlap=1 → q high after bit 3 and after bit 5, match_cnt=2. Then stream 1,1,0,1 → one more match, match_cnt=3.
- i_vld gaps: bits 1,(gap×3),0,(gap),1 → q high only on the edge after the last valid bit. q=0 during gaps.
- pat_load with pat_in=3'b110 mid-stream after bits 1,1, then stream 1,1,0 → the earlier 1,1 is discarded, q high after the third post-load bit, pat=110.
- Saturation with CNT_W=2, overlap=1, pattern 11, stream of seven 1s → six matches, match_cnt sticks at 3. cnt_clr on the same edge as a hit → match_cnt=0 and q=1.
- Asynchronous rst asserted between clock edges after bits 1,0 → outputs reset immediately with no clk edge. After release, stream 1 → no q, confirming the partial match was lost.
